// File: rtl/copro_alu_pipe_pkg.sv
// Coprocessor instruction types, tag types and the 64-bit rotate helper
// shared by the ALU pipeline, its bus interface and the testbench.
package copro_alu_pipe_pkg;

   typedef logic [31:0] hartid_t;
   typedef logic [3:0]  id_t;

   typedef enum logic [3:0] {
      NOP          = 4'd0,
      ADD          = 4'd1,
      DOUBLE_RS1   = 4'd2,
      DOUBLE_RS2   = 4'd3,
      ADD_MULTI    = 4'd4,
      ADD_RS3_R    = 4'd5,
      MADD_RS3_R4  = 4'd6,
      MSUB_RS3_R4  = 4'd7,
      NMADD_RS3_R4 = 4'd8,
      NMSUB_RS3_R4 = 4'd9,
      ROR64H       = 4'd10,
      ROR64L       = 4'd11,
      ROL64H       = 4'd12,
      ROL64L       = 4'd13
   } opcode_t;

   typedef enum logic {
      ROT_RIGHT = 1'b0,
      ROT_LEFT  = 1'b1
   } rot_dir_e;

   // Rotating a doubled copy keeps every amount 0..63 well defined,
   // including 0 (identity) and 32 (half swap).
   function automatic logic [63:0] rot64(input logic [31:0] hi,
                                         input logic [31:0] lo,
                                         input logic [5:0]  amount,
                                         input rot_dir_e    dir);
      logic [127:0] dbl;
      logic [127:0] sh;
      dbl = {hi, lo, hi, lo};
      if (dir == ROT_LEFT) begin
         sh = dbl << amount;
         return sh[127:64];
      end
      sh = dbl >> amount;
      return sh[63:0];
   endfunction

endpackage

// File: rtl/copro_alu_pipe_if.sv
// Issue and result handshake bundle between the decoder stage, the ALU
// pipeline (slave) and the result consumer.
interface copro_alu_pipe_if #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NrRgprPorts = 2
);
   import copro_alu_pipe_pkg::*;

   logic                              issue_valid_i;
   logic                              issue_ready_o;
   logic [NrRgprPorts-1:0][XLEN-1:0]  registers_i;
   opcode_t                           opcode_i;
   hartid_t                           hartid_i;
   id_t                               id_i;
   logic [4:0]                        rd_i;
   logic [5:0]                        imm_i;

   logic                              result_valid_o;
   logic                              result_ready_i;
   logic [XLEN-1:0]                   result_o;
   hartid_t                           hartid_o;
   id_t                               id_o;
   logic [4:0]                        rd_o;
   logic                              we_o;

   modport slave (
      input  issue_valid_i, registers_i, opcode_i, hartid_i, id_i, rd_i, imm_i,
      input  result_ready_i,
      output issue_ready_o,
      output result_valid_o, result_o, hartid_o, id_o, rd_o, we_o
   );

   modport master (
      output issue_valid_i, registers_i, opcode_i, hartid_i, id_i, rd_i, imm_i,
      output result_ready_i,
      input  issue_ready_o,
      input  result_valid_o, result_o, hartid_o, id_o, rd_o, we_o
   );

endinterface

// File: rtl/copro_alu_pipe_result_fifo.sv
// Result FIFO with a registered head; a push into an empty FIFO is visible
// the next cycle. Head holds while not taken; flush empties it at the next edge.
module copro_result_fifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic [W-1:0] push_dat_i,
   output logic         head_vld_o,
   input  logic         head_rdy_i,
   output logic [W-1:0] head_dat_o
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned SLOTS = 1 << PTR_W;

   logic [W-1:0]     mem_q [SLOTS];
   logic [W-1:0]     mem_d [SLOTS];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             head_vld_q, head_vld_d;
   logic [W-1:0]     head_dat_q, head_dat_d;
   logic             pop;
   logic             buf_empty;

   always_comb begin
      pop        = head_vld_q & head_rdy_i;
      buf_empty  = (cnt_q == '0);
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      head_vld_d = head_vld_q;
      head_dat_d = head_dat_q;
      if (pop) begin
         if (!buf_empty) begin
            head_dat_d = mem_q[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + 1'b1;
            cnt_d      = cnt_q - 1'b1;
         end else begin
            head_vld_d = 1'b0;
         end
      end
      // Bypass into the head only when nothing older is waiting behind it.
      if (push_i) begin
         if (!head_vld_q || (pop && buf_empty)) begin
            head_vld_d = 1'b1;
            head_dat_d = push_dat_i;
         end else begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            cnt_d           = cnt_d + 1'b1;
         end
      end
      if (flush_i) begin
         head_vld_d = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         cnt_d      = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < SLOTS; i++) mem_q[i] <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         head_vld_q <= 1'b0;
         head_dat_q <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         head_vld_q <= head_vld_d;
         head_dat_q <= head_dat_d;
      end
   end

   assign head_vld_o = head_vld_q;
   assign head_dat_o = head_dat_q;

endmodule

// File: rtl/copro_alu_pipe.sv
// Pipelined coprocessor ALU: compute at issue, Latency cycles to result_valid_o.
// Credits bound in-flight plus buffered work to FifoDepth, so issue stalls instead of dropping.
module copro_alu_pipe
   import copro_alu_pipe_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NrRgprPorts = 2,
   parameter int unsigned Latency     = 2,
   parameter int unsigned FifoDepth   = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   copro_alu_pipe_if.slave  bus
);
   localparam int unsigned UW = $clog2(FifoDepth + 1);

   typedef struct packed {
      logic [XLEN-1:0] result;
      hartid_t         hartid;
      id_t             id;
      logic [4:0]      rd;
      logic            we;
   } entry_t;

   logic [UW-1:0]   used_q, used_d;
   logic            issue_ready;
   logic            accept;
   logic            pop;
   logic [XLEN-1:0] rs1, rs2, rs3;
   logic [XLEN-1:0] sum3, dif3;
   logic [63:0]     rot_r, rot_l;
   entry_t          alu_dat;
   entry_t          fifo_dat;
   logic            fifo_push;
   entry_t          head_dat;
   logic            head_vld;

   assign rs1 = bus.registers_i[0];
   assign rs2 = bus.registers_i[1];
   if (NrRgprPorts == 3) begin : g_rs3
      assign rs3 = bus.registers_i[2];
   end else begin : g_no_rs3
      assign rs3 = '0;
   end

   // Credits count accepted-but-not-popped work, so readiness never looks at issue_valid_i.
   assign issue_ready       = ~rst_i & ~flush_i & (used_q < UW'(FifoDepth));
   assign bus.issue_ready_o = issue_ready;
   assign accept            = bus.issue_valid_i & issue_ready;
   assign pop               = head_vld & bus.result_ready_i;

   always_comb begin
      used_d = used_q;
      if (flush_i) begin
         used_d = '0;
      end else if (accept && !pop) begin
         used_d = used_q + 1'b1;
      end else if (!accept && pop) begin
         used_d = used_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) used_q <= '0;
      else       used_q <= used_d;
   end

   always_comb begin
      sum3           = rs1 + rs2 + rs3;
      dif3           = rs1 - rs2 - rs3;
      rot_r          = rot64(rs1[31:0], rs2[31:0], bus.imm_i, ROT_RIGHT);
      rot_l          = rot64(rs1[31:0], rs2[31:0], bus.imm_i, ROT_LEFT);
      alu_dat        = '0;
      alu_dat.hartid = bus.hartid_i;
      alu_dat.id     = bus.id_i;
      alu_dat.rd     = bus.rd_i;
      alu_dat.we     = 1'b1;
      case (bus.opcode_i)
         NOP: begin
            alu_dat.rd = '0;
            alu_dat.we = 1'b0;
         end
         ADD, ADD_MULTI: alu_dat.result = rs1 + rs2;
         DOUBLE_RS1:     alu_dat.result = rs1 << 1;
         DOUBLE_RS2:     alu_dat.result = rs2 << 1;
         MADD_RS3_R4:    alu_dat.result = sum3;
         MSUB_RS3_R4:    alu_dat.result = dif3;
         NMADD_RS3_R4:   alu_dat.result = ~sum3;
         NMSUB_RS3_R4:   alu_dat.result = ~dif3;
         ADD_RS3_R: begin
            alu_dat.result = sum3;
            alu_dat.rd     = 5'd10;
         end
         ROR64H:  alu_dat.result = XLEN'(rot_r[63:32]);
         ROR64L:  alu_dat.result = XLEN'(rot_r[31:0]);
         ROL64H:  alu_dat.result = XLEN'(rot_l[63:32]);
         ROL64L:  alu_dat.result = XLEN'(rot_l[31:0]);
         default: alu_dat.we = 1'b0;
      endcase
   end

   // The FIFO head register is the final stage; these are the ones before it.
   if (Latency > 1) begin : g_stages
      localparam int unsigned NS = Latency - 1;
      logic [NS-1:0] vld_q, vld_d;
      entry_t        dat_q [NS];
      entry_t        dat_d [NS];

      always_comb begin
         vld_d[0] = accept;
         dat_d[0] = alu_dat;
         for (int i = 1; i < NS; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
         end
         if (flush_i) vld_d = '0;
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < NS; i++) dat_q[i] <= '0;
         end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
         end
      end

      assign fifo_push = vld_q[NS-1];
      assign fifo_dat  = dat_q[NS-1];
   end else begin : g_direct
      assign fifo_push = accept;
      assign fifo_dat  = alu_dat;
   end

   copro_result_fifo #(
      .W     ($bits(entry_t)),
      .DEPTH (FifoDepth)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (flush_i),
      .push_i     (fifo_push),
      .push_dat_i (fifo_dat),
      .head_vld_o (head_vld),
      .head_rdy_i (bus.result_ready_i),
      .head_dat_o (head_dat)
   );

   assign bus.result_valid_o = head_vld;
   assign bus.result_o       = head_dat.result;
   assign bus.hartid_o       = head_dat.hartid;
   assign bus.id_o           = head_dat.id;
   assign bus.rd_o           = head_dat.rd;
   assign bus.we_o           = head_dat.we;

endmodule
